// File: rtl/card_dealer_if.sv
// card_dealer_if: deal request handshake and dealt-card / hand-status bundle
// between the game FSM (master) and the card dealer (slave).
//   deal_req/deal_to    : one-card request and its destination hand
//   new_deck            : rewind the deck pointer to 0
//   clear_hands         : zero both hand totals and ace flags
//   deal_ready          : dealer idle with at least one card left
//   card_valid/value/dest/err : one-cycle dealt-card pulse
//   cards_left/deck_empty     : deck status
//   player_/dealer_score/bust : best hand totals and bust flags
interface card_dealer_if;
    logic       deal_req;
    logic       deal_to;
    logic       new_deck;
    logic       clear_hands;
    logic       deal_ready;
    logic       card_valid;
    logic [3:0] card_value;
    logic       card_dest;
    logic       card_err;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic [4:0] player_score;
    logic [4:0] dealer_score;
    logic       player_bust;
    logic       dealer_bust;

    modport master (
        output deal_req, deal_to, new_deck, clear_hands,
        input  deal_ready, card_valid, card_value, card_dest, card_err,
               cards_left, deck_empty, player_score, dealer_score,
               player_bust, dealer_bust
    );

    modport slave (
        input  deal_req, deal_to, new_deck, clear_hands,
        output deal_ready, card_valid, card_value, card_dest, card_err,
               cards_left, deck_empty, player_score, dealer_score,
               player_bust, dealer_bust
    );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: read-only client of the deck memory. Walks the deck one card
// per accepted request, emits each card with a one-cycle valid pulse and
// keeps blackjack totals (soft-ace aware) for player and dealer.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   dif (slave)  : deal handshake, card output and hand status
//   mem_addr     : read address to the deck ram (always the deck pointer)
//   mem_rd_data  : registered ram read data
//
// state | meaning
// IDLE  | waiting for a deal request
// ADDR  | pointer presented to ram, ram samples it this cycle
// CAPT  | ram data valid, captured and accumulated at end of cycle
module card_dealer #(
    parameter int DECK_SIZE = 52
) (
    input  logic          clk,
    input  logic          rst_n,
    card_dealer_if.slave  dif,
    output logic [5:0]    mem_addr,
    input  logic [3:0]    mem_rd_data
);
    typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

    localparam logic [5:0] DECK_LAST = 6'(DECK_SIZE);

    state_t     state_q, state_d;
    logic [5:0] ptr_q, ptr_d;
    logic       dest_q, dest_d;
    logic       valid_q, valid_d;
    logic [3:0] value_q, value_d;
    logic       cdest_q, cdest_d;
    logic       err_q, err_d;
    logic [4:0] p_raw_q, p_raw_d;
    logic       p_ace_q, p_ace_d;
    logic [4:0] d_raw_q, d_raw_d;
    logic       d_ace_q, d_ace_d;

    logic deck_empty;
    logic deal_ready;
    logic legal;

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [3:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {2'b00, b};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    // An ace counts 11 only while that keeps the hand at 21 or below.
    function automatic logic [4:0] best_score(input logic [4:0] raw, input logic ace);
        logic [5:0] t;
        t = {1'b0, raw} + 6'd10;
        return (ace && t <= 6'd21) ? t[4:0] : raw;
    endfunction

    assign deck_empty = (ptr_q == DECK_LAST);
    assign deal_ready = (state_q == IDLE) && !deck_empty;
    assign legal      = (mem_rd_data >= 4'd1) && (mem_rd_data <= 4'd10);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dest_d  = dest_q;
        valid_d = 1'b0;
        value_d = value_q;
        cdest_d = cdest_q;
        err_d   = 1'b0;
        p_raw_d = p_raw_q;
        p_ace_d = p_ace_q;
        d_raw_d = d_raw_q;
        d_ace_d = d_ace_q;

        case (state_q)
            IDLE: begin
                if (dif.new_deck) begin
                    ptr_d = 6'd0;
                end else if (dif.deal_req && deal_ready) begin
                    dest_d  = dif.deal_to;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (dif.new_deck) begin
                    ptr_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                state_d = IDLE;
                if (dif.new_deck) begin
                    ptr_d = 6'd0;
                end else begin
                    valid_d = 1'b1;
                    value_d = mem_rd_data;
                    cdest_d = dest_q;
                    err_d   = !legal;
                    ptr_d   = ptr_q + 6'd1;
                    if (legal) begin
                        if (dest_q) begin
                            d_raw_d = sat_add(d_raw_q, mem_rd_data);
                            d_ace_d = d_ace_q || (mem_rd_data == 4'd1);
                        end else begin
                            p_raw_d = sat_add(p_raw_q, mem_rd_data);
                            p_ace_d = p_ace_q || (mem_rd_data == 4'd1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing overrides any accumulation on the same edge.
        if (dif.clear_hands) begin
            p_raw_d = 5'd0;
            p_ace_d = 1'b0;
            d_raw_d = 5'd0;
            d_ace_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 6'd0;
            dest_q  <= 1'b0;
            valid_q <= 1'b0;
            value_q <= 4'd0;
            cdest_q <= 1'b0;
            err_q   <= 1'b0;
            p_raw_q <= 5'd0;
            p_ace_q <= 1'b0;
            d_raw_q <= 5'd0;
            d_ace_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            value_q <= value_d;
            cdest_q <= cdest_d;
            err_q   <= err_d;
            p_raw_q <= p_raw_d;
            p_ace_q <= p_ace_d;
            d_raw_q <= d_raw_d;
            d_ace_q <= d_ace_d;
        end
    end

    assign mem_addr         = ptr_q;
    assign dif.deal_ready   = deal_ready;
    assign dif.deck_empty   = deck_empty;
    assign dif.cards_left   = DECK_LAST - ptr_q;
    assign dif.card_valid   = valid_q;
    assign dif.card_value   = value_q;
    assign dif.card_dest    = cdest_q;
    assign dif.card_err     = err_q;
    assign dif.player_score = best_score(p_raw_q, p_ace_q);
    assign dif.dealer_score = best_score(d_raw_q, d_ace_q);
    assign dif.player_bust  = (best_score(p_raw_q, p_ace_q) > 5'd21);
    assign dif.dealer_bust  = (best_score(d_raw_q, d_ace_q) > 5'd21);
endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] mem_addr;
    logic [3:0] mem_rd_data;
    logic [3:0] mem [0:51];

    card_dealer_if dif();

    card_dealer #(.DECK_SIZE(52)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dif(dif.slave),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Registered-read deck memory model.
    always @(posedge clk) mem_rd_data <= (mem_addr < 6'd52) ? mem[mem_addr] : 4'd0;

    typedef struct packed {
        logic [3:0] value;
        logic       dest;
        logic       err;
    } exp_t;

    typedef struct {
        bit         clr;
        bit         dest;
        logic [3:0] val;
        int         p;
        int         d;
        bit         pb;
        bit         db;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pulse = 0;
    int   exp_ptr = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && dif.card_valid) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check("unexpected_card_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("card_value", dif.card_value, e.value);
                check("card_dest", dif.card_dest, e.dest);
                check("card_err", dif.card_err, e.err);
            end
        end
    end

    // Called at a negedge with the dealer idle and cards remaining.
    task automatic deal(input bit dest, input logic [3:0] val, input bit clr_capt);
        exp_t e;
        mem[exp_ptr] = val;
        e.value = val;
        e.dest  = dest;
        e.err   = (val == 4'd0) || (val > 4'd10);
        sb_q.push_back(e);
        dif.deal_req = 1'b1;
        dif.deal_to  = dest;
        @(posedge clk); @(negedge clk);
        dif.deal_req = 1'b0;
        check("ready_falls", dif.deal_ready, 0);
        @(posedge clk); @(negedge clk);
        check("no_early_valid", dif.card_valid, 0);
        if (clr_capt) dif.clear_hands = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.clear_hands = 1'b0;
        check("latency_valid", dif.card_valid, 1);
        exp_ptr++;
        check("ready_rises", dif.deal_ready, (exp_ptr < 52) ? 1 : 0);
    endtask

    task automatic clear_pulse();
        dif.clear_hands = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.clear_hands = 1'b0;
        check("clear_player", dif.player_score, 0);
        check("clear_dealer", dif.dealer_score, 0);
        check("clear_pbust", dif.player_bust, 0);
    endtask

    task automatic check_rewound(input string tag);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_ready"}, dif.deal_ready, 1);
        check({tag, "_cards_left"}, dif.cards_left, 52);
    endtask

    initial begin
        int base;
        dif.deal_req    = 1'b0;
        dif.deal_to     = 1'b0;
        dif.new_deck    = 1'b0;
        dif.clear_hands = 1'b0;
        for (int i = 0; i < 52; i++) mem[i] = 4'((i % 10) + 1);

        //             clr dest val  p   d  pb db
        vecs[0]  = '{0, 0, 4'd1,  11,  0, 0, 0};
        vecs[1]  = '{0, 1, 4'd10, 11, 10, 0, 0};
        vecs[2]  = '{0, 1, 4'd1,  11, 21, 0, 0};
        vecs[3]  = '{0, 1, 4'd5,  11, 16, 0, 0};
        vecs[4]  = '{1, 0, 4'd10, 10,  0, 0, 0};
        vecs[5]  = '{0, 0, 4'd10, 20,  0, 0, 0};
        vecs[6]  = '{0, 0, 4'd5,  25,  0, 1, 0};
        vecs[7]  = '{1, 0, 4'd7,   7,  0, 0, 0};
        vecs[8]  = '{0, 0, 4'd0,   7,  0, 0, 0};
        vecs[9]  = '{0, 1, 4'd12,  7,  0, 0, 0};
        vecs[10] = '{0, 0, 4'd1,  18,  0, 0, 0};
        vecs[11] = '{0, 0, 4'd4,  12,  0, 0, 0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", dif.card_valid, 0);
        check("rst_value", dif.card_value, 0);
        check("rst_cards_left", dif.cards_left, 52);
        check("rst_deck_empty", dif.deck_empty, 0);
        check("rst_ready", dif.deal_ready, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pscore", dif.player_score, 0);
        check("rst_dscore", dif.dealer_score, 0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].clr) clear_pulse();
            deal(vecs[i].dest, vecs[i].val, 1'b0);
            check("player_score", dif.player_score, vecs[i].p);
            check("dealer_score", dif.dealer_score, vecs[i].d);
            check("player_bust", dif.player_bust, vecs[i].pb);
            check("dealer_bust", dif.dealer_bust, vecs[i].db);
            check("cards_left", dif.cards_left, 52 - exp_ptr);
        end

        // Clear on the capture edge: card emitted, not accumulated.
        deal(1'b0, 4'd5, 1'b1);
        check("clear_beats_accum", dif.player_score, 0);

        // new_deck during ADDR.
        mem[exp_ptr] = 4'd9;
        dif.deal_req = 1'b1;
        dif.deal_to  = 1'b0;
        @(posedge clk); @(negedge clk);
        dif.deal_req = 1'b0;
        dif.new_deck = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.new_deck = 1'b0;
        exp_ptr = 0;
        check_rewound("abort_addr");
        repeat (4) @(negedge clk);

        // new_deck during CAPT.
        deal(1'b1, 4'd3, 1'b0);
        dif.deal_req = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.deal_req = 1'b0;
        @(posedge clk); @(negedge clk);
        dif.new_deck = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.new_deck = 1'b0;
        exp_ptr = 0;
        check_rewound("abort_capt");
        repeat (4) @(negedge clk);

        // new_deck and deal_req together in IDLE: request dropped.
        deal(1'b1, 4'd2, 1'b0);
        dif.new_deck = 1'b1;
        dif.deal_req = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.new_deck = 1'b0;
        dif.deal_req = 1'b0;
        exp_ptr = 0;
        check_rewound("newdeck_beats_req");
        repeat (5) @(negedge clk);

        // Reset asserted in CAPT.
        deal(1'b0, 4'd7, 1'b0);
        check("pre_reset_player", dif.player_score, 7);
        dif.deal_req = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.deal_req = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", dif.card_valid, 0);
        check("mid_rst_cards_left", dif.cards_left, 52);
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_pscore", dif.player_score, 0);
        check("mid_rst_dscore", dif.dealer_score, 0);
        check("mid_rst_ready", dif.deal_ready, 1);
        check("mid_rst_value", dif.card_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ptr = 0;
        repeat (5) @(negedge clk);

        // 52 back-to-back requests with deal_req held high, then one extra.
        for (int i = 0; i < 52; i++) begin
            exp_t e;
            mem[i]  = 4'((i % 10) + 1);
            e.value = 4'((i % 10) + 1);
            e.dest  = 1'b1;
            e.err   = 1'b0;
            sb_q.push_back(e);
        end
        base = n_pulse;
        dif.deal_req = 1'b1;
        dif.deal_to  = 1'b1;
        repeat (52 * 3 + 12) @(negedge clk);
        dif.deal_req = 1'b0;
        check("b2b_pulses", n_pulse - base, 52);
        check("b2b_deck_empty", dif.deck_empty, 1);
        check("b2b_ready", dif.deal_ready, 0);
        check("b2b_cards_left", dif.cards_left, 0);
        check("dealer_saturated", dif.dealer_score, 31);
        dif.new_deck = 1'b1;
        @(posedge clk); @(negedge clk);
        dif.new_deck = 1'b0;
        check_rewound("refill");
        check("refill_deck_empty", dif.deck_empty, 0);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
